// File: rtl/matmul_loop_seq.sv
// Loop/address sequencer for one matrix-multiply core (D = A x B).
// Walks i/j/k with k innermost and rows striped over N_CORES; emits one beat per MAC step.
module matmul_loop_seq #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned N_CORES = 1,
  parameter int unsigned CORE_ID = 0
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              first_k,
  output logic              last_k,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  localparam logic [DIM_W:0]    NCoresI = (DIM_W+1)'(N_CORES);
  localparam logic [DIM_W:0]    CoreIdI = (DIM_W+1)'(CORE_ID);
  localparam logic [ADDR_W-1:0] NCoresA = ADDR_W'(N_CORES);
  localparam logic [ADDR_W-1:0] CoreIdA = ADDR_W'(CORE_ID);

  state_e              r_state;
  logic [DIM_W:0]      r_i;
  logic [DIM_W:0]      r_dim_i;
  logic [DIM_W-1:0]    r_j;
  logic [DIM_W-1:0]    r_k;
  logic [DIM_W-1:0]    r_jmax;
  logic [DIM_W-1:0]    r_kmax;
  logic [ADDR_W-1:0]   r_base_b;
  logic [ADDR_W-1:0]   r_col_b;
  logic [ADDR_W-1:0]   r_row_a;
  logic [ADDR_W-1:0]   r_row_d;
  logic [ADDR_W-1:0]   r_step_a;
  logic [ADDR_W-1:0]   r_step_b;
  logic [ADDR_W-1:0]   r_step_d;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic [ADDR_W-1:0]   r_addr_d;
  logic                r_first;
  logic                r_last;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_go;
  logic                w_k_end;
  logic                w_j_end;
  logic                w_i_end;
  logic [DIM_W:0]      w_i_next;
  logic [ADDR_W-1:0]   w_dim_j_a;
  logic [ADDR_W-1:0]   w_dim_k_a;
  logic [ADDR_W-1:0]   w_row_a0;
  logic [ADDR_W-1:0]   w_row_d0;
  logic [ADDR_W-1:0]   w_row_a_nx;
  logic [ADDR_W-1:0]   w_row_d_nx;
  logic [ADDR_W-1:0]   w_col_b_nx;

  always_comb begin
    w_accept   = r_valid & beat_ready;
    w_go       = (CoreIdI < {1'b0, dim_i}) && (dim_j != '0) && (dim_k != '0);
    w_k_end    = (r_k == r_kmax);
    w_j_end    = (r_j == r_jmax);
    // i is one bit wider than the dims so the stride cannot wrap before the compare
    w_i_next   = r_i + NCoresI;
    w_i_end    = (w_i_next >= r_dim_i);
    w_dim_j_a  = ADDR_W'(dim_j);
    w_dim_k_a  = ADDR_W'(dim_k);
    w_row_a0   = base_a + CoreIdA * w_dim_k_a;
    w_row_d0   = base_d + CoreIdA * w_dim_j_a;
    w_row_a_nx = r_row_a + r_step_a;
    w_row_d_nx = r_row_d + r_step_d;
    w_col_b_nx = r_col_b + ADDR_W'(1);
  end

  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      r_state  <= StIdle;
      r_i      <= '0;
      r_dim_i  <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_jmax   <= '0;
      r_kmax   <= '0;
      r_base_b <= '0;
      r_col_b  <= '0;
      r_row_a  <= '0;
      r_row_d  <= '0;
      r_step_a <= '0;
      r_step_b <= '0;
      r_step_d <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_d <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_dim_i  <= {1'b0, dim_i};
            r_jmax   <= dim_j - DIM_W'(1);
            r_kmax   <= dim_k - DIM_W'(1);
            r_base_b <= base_b;
            r_col_b  <= base_b;
            r_row_a  <= w_row_a0;
            r_row_d  <= w_row_d0;
            r_step_a <= NCoresA * w_dim_k_a;
            r_step_b <= w_dim_j_a;
            r_step_d <= NCoresA * w_dim_j_a;
            r_i      <= CoreIdI;
            r_j      <= '0;
            r_k      <= '0;
            if (w_go) begin
              r_state  <= StIssue;
              r_valid  <= 1'b1;
              r_busy   <= 1'b1;
              r_addr_a <= w_row_a0;
              r_addr_b <= base_b;
              r_addr_d <= w_row_d0;
              r_first  <= 1'b1;
              r_last   <= (dim_k == DIM_W'(1));
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (w_accept) begin
            if (!w_k_end) begin
              r_k      <= r_k + DIM_W'(1);
              r_addr_a <= r_addr_a + ADDR_W'(1);
              r_addr_b <= r_addr_b + r_step_b;
              r_first  <= 1'b0;
              r_last   <= ((r_k + DIM_W'(1)) == r_kmax);
            end else if (!w_j_end) begin
              r_k      <= '0;
              r_j      <= r_j + DIM_W'(1);
              r_col_b  <= w_col_b_nx;
              r_addr_a <= r_row_a;
              r_addr_b <= w_col_b_nx;
              r_addr_d <= r_addr_d + ADDR_W'(1);
              r_first  <= 1'b1;
              r_last   <= (r_kmax == '0);
            end else if (!w_i_end) begin
              r_k      <= '0;
              r_j      <= '0;
              r_i      <= w_i_next;
              r_row_a  <= w_row_a_nx;
              r_row_d  <= w_row_d_nx;
              r_col_b  <= r_base_b;
              r_addr_a <= w_row_a_nx;
              r_addr_b <= r_base_b;
              r_addr_d <= w_row_d_nx;
              r_first  <= 1'b1;
              r_last   <= (r_kmax == '0);
            end else begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_first <= 1'b0;
              r_last  <= 1'b0;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign beat_valid = r_valid;
  assign addr_a     = r_addr_a;
  assign addr_b     = r_addr_b;
  assign addr_d     = r_addr_d;
  assign first_k    = r_first;
  assign last_k     = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_matmul_loop_seq.sv
// Bench for matmul_loop_seq: a reference loop model fills a beat queue that is
// drained as the DUT's beats are accepted. Two instances cover 1-core and 2-core striping.
module tb_matmul_loop_seq;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1, ready;
  logic [7:0] dim_i, dim_j, dim_k, base_a, base_b, base_d;
  logic       valid0, busy0, done0, first0, last0;
  logic       valid1, busy1, done1, first1, last1;
  logic [7:0] a0, b0, d0, a1, b1, d1;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  matmul_loop_seq #(.ADDR_W(8), .DIM_W(8), .N_CORES(1), .CORE_ID(0)) u_dut0 (
    .clock(clk), .RST(rst), .start(start0),
    .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .beat_valid(valid0), .beat_ready(ready),
    .addr_a(a0), .addr_b(b0), .addr_d(d0),
    .first_k(first0), .last_k(last0), .busy(busy0), .done(done0)
  );

  matmul_loop_seq #(.ADDR_W(8), .DIM_W(8), .N_CORES(2), .CORE_ID(1)) u_dut1 (
    .clock(clk), .RST(rst), .start(start1),
    .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .beat_valid(valid1), .beat_ready(ready),
    .addr_a(a1), .addr_b(b1), .addr_d(d1),
    .first_k(first1), .last_k(last1), .busy(busy1), .done(done1)
  );

  task automatic push_job(input int nc, input int cid, input int ni, input int nj, input int nk,
                          input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd);
    beat_t e;
    for (int i = cid; i < ni; i += nc)
      for (int j = 0; j < nj; j++)
        for (int k = 0; k < nk; k++) begin
          e.a = 8'(int'(ba) + i * nk + k);
          e.b = 8'(int'(bb) + k * nj + j);
          e.d = 8'(int'(bd) + i * nj + j);
          e.f = (k == 0);
          e.l = (k == nk - 1);
          sb.push_back(e);
        end
  endtask

  // Pulses start for one cycle, then scrambles the operand inputs to prove they were latched.
  task automatic kick(input bit sel, input int ni, input int nj, input int nk,
                      input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd);
    @(negedge clk);
    dim_i = 8'(ni); dim_j = 8'(nj); dim_k = 8'(nk);
    base_a = ba; base_b = bb; base_d = bd;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    dim_i = 8'($urandom); dim_j = 8'($urandom); dim_k = 8'($urandom);
    base_a = 8'($urandom); base_b = 8'($urandom); base_d = 8'($urandom);
  endtask

  task automatic collect(input bit sel, input int stall_beat, input int stall_len,
                         input bit rand_ready, input int abort_after, input bit poke,
                         input string name);
    int         cyc, beats, stalls, last_acc;
    bit         got_done, hold, stall_now;
    logic       v, bz, dn, f, l;
    logic [7:0] a, b, d;
    beat_t      exp_b;
    cyc = 0; beats = 0; stalls = 0; last_acc = -1; got_done = 1'b0;
    while (cyc < 400) begin
      if (sel) begin v = valid1; bz = busy1; dn = done1; f = first1; l = last1; a = a1; b = b1; d = d1; end
      else     begin v = valid0; bz = busy0; dn = done0; f = first0; l = last0; a = a0; b = b0; d = d0; end
      if (dn) begin
        got_done = 1'b1;
        n_checks++;
        if (cyc !== last_acc + 1 || v !== 1'b0) begin
          n_errors++;
          $display("FAIL %s done_timing: done at cycle %0d valid=%b, required cycle %0d valid=0",
                   name, cyc, v, last_acc + 1);
        end
        break;
      end
      hold = 1'b0;
      n_checks++;
      if (v !== 1'b1 || bz !== 1'b1) begin
        n_errors++;
        $display("FAIL %s bubble: cycle %0d valid=%b busy=%b, required 1/1", name, cyc, v, bz);
      end else if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL %s extra_beat: a=%h b=%h d=%h, required no beat", name, a, b, d);
      end else begin
        exp_b = sb[0];
        if ({a, b, d, f, l} !== exp_b) begin
          n_errors++;
          $display("FAIL %s beat %0d: got a=%h b=%h d=%h f=%b l=%b, required a=%h b=%h d=%h f=%b l=%b",
                   name, beats + 1, a, b, d, f, l, exp_b.a, exp_b.b, exp_b.d, exp_b.f, exp_b.l);
        end
        stall_now = (beats + 1 == stall_beat) && (stalls < stall_len);
        hold = stall_now || (rand_ready && $urandom_range(0, 2) == 0);
        if (stall_now) stalls++;
      end
      if (hold) ready = 1'b0;
      else begin
        ready = 1'b1;
        if (v === 1'b1 && sb.size() > 0) begin
          void'(sb.pop_front());
          beats++;
          last_acc = cyc;
        end
      end
      if (sel) start1 = poke && (beats == 3);
      else     start0 = poke && (beats == 3);
      if (abort_after > 0 && beats == abort_after) begin
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; ready = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0; ready = 1'b1;
    n_checks++;
    if (!got_done) begin
      n_errors++;
      $display("FAIL %s timeout: done=0 after %0d cycles, required done", name, cyc);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s missing_beats: %0d left, required 0", name, sb.size());
    end
    @(negedge clk);
    if (sel) begin v = valid1; dn = done1; end else begin v = valid0; dn = done0; end
    n_checks++;
    if (dn !== 1'b0 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL %s done_pulse: done=%b valid=%b after done, required 0/0", name, dn, v);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({valid0, busy0, done0, first0, last0, a0, b0, d0} !== 29'd0) begin
      n_errors++;
      $display("FAIL reset_dut0: outputs=%h, required 0",
               {valid0, busy0, done0, first0, last0, a0, b0, d0});
    end
    n_checks++;
    if ({valid1, busy1, done1, first1, last1, a1, b1, d1} !== 29'd0) begin
      n_errors++;
      $display("FAIL reset_dut1: outputs=%h, required 0",
               {valid1, busy1, done1, first1, last1, a1, b1, d1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    push_job(1, 0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    kick(1'b0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    collect(1'b0, 0, 0, 1'b0, 0, 1'b0, "basic");
  endtask

  task automatic test_partition;
    push_job(2, 1, 3, 1, 1, 8'h00, 8'h00, 8'h00);
    kick(1'b1, 3, 1, 1, 8'h00, 8'h00, 8'h00);
    collect(1'b1, 0, 0, 1'b0, 0, 1'b0, "partition");
  endtask

  task automatic test_stall;
    push_job(1, 0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    kick(1'b0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    collect(1'b0, 3, 3, 1'b0, 0, 1'b0, "stall");
  endtask

  task automatic test_degenerate;
    kick(1'b0, 2, 2, 0, 8'h00, 8'h10, 8'h20);
    n_checks++;
    if ({done0, valid0, busy0} !== 3'b100) begin
      n_errors++;
      $display("FAIL degen_k0: done/valid/busy=%b, required 100", {done0, valid0, busy0});
    end
    // A start presented while in DONE must be dropped.
    dim_i = 8'd2; dim_j = 8'd2; dim_k = 8'd2; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_checks++;
    if ({done0, valid0, busy0} !== 3'b000) begin
      n_errors++;
      $display("FAIL degen_start_in_done: done/valid/busy=%b, required 000", {done0, valid0, busy0});
    end
    @(negedge clk);
    n_checks++;
    if ({done0, valid0, busy0} !== 3'b000) begin
      n_errors++;
      $display("FAIL degen_idle: done/valid/busy=%b, required 000", {done0, valid0, busy0});
    end
    kick(1'b1, 1, 4, 4, 8'h00, 8'h00, 8'h00);
    n_checks++;
    if ({done1, valid1, busy1} !== 3'b100) begin
      n_errors++;
      $display("FAIL degen_no_rows: done/valid/busy=%b, required 100", {done1, valid1, busy1});
    end
    @(negedge clk);
    n_checks++;
    if ({done1, valid1, busy1} !== 3'b000) begin
      n_errors++;
      $display("FAIL degen_no_rows_after: done/valid/busy=%b, required 000", {done1, valid1, busy1});
    end
  endtask

  task automatic test_reset_midjob;
    push_job(1, 0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    kick(1'b0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    collect(1'b0, 0, 0, 1'b0, 5, 1'b0, "midjob_pre");
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({valid0, busy0, done0, first0, last0, a0, b0, d0} !== 29'd0) begin
      n_errors++;
      $display("FAIL midjob_reset: outputs=%h, required 0",
               {valid0, busy0, done0, first0, last0, a0, b0, d0});
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    push_job(1, 0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    kick(1'b0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    collect(1'b0, 0, 0, 1'b0, 0, 1'b1, "midjob_restart");
  endtask

  task automatic test_wrap;
    push_job(1, 0, 1, 1, 4, 8'hFE, 8'h40, 8'h80);
    kick(1'b0, 1, 1, 4, 8'hFE, 8'h40, 8'h80);
    collect(1'b0, 0, 0, 1'b0, 0, 1'b0, "wrap");
  endtask

  task automatic test_back_to_back;
    logic [7:0] ba, bb, bd;
    ba = 8'($urandom); bb = 8'($urandom); bd = 8'($urandom);
    push_job(2, 1, 5, 3, 2, ba, bb, bd);
    kick(1'b1, 5, 3, 2, ba, bb, bd);
    collect(1'b1, 0, 0, 1'b1, 0, 1'b1, "b2b_core1");
    ba = 8'($urandom); bb = 8'($urandom); bd = 8'($urandom);
    push_job(1, 0, 3, 2, 3, ba, bb, bd);
    kick(1'b0, 3, 2, 3, ba, bb, bd);
    collect(1'b0, 0, 0, 1'b1, 0, 1'b0, "b2b_core0");
    push_job(1, 0, 2, 3, 1, 8'hF0, 8'hFD, 8'hFC);
    kick(1'b0, 2, 3, 1, 8'hF0, 8'hFD, 8'hFC);
    collect(1'b0, 0, 0, 1'b0, 0, 1'b0, "b2b_k1");
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready = 1'b1;
    dim_i = '0; dim_j = '0; dim_k = '0; base_a = '0; base_b = '0; base_d = '0;
    test_reset;
    test_basic;
    test_partition;
    test_stall;
    test_degenerate;
    test_reset_midjob;
    test_wrap;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
